// File: rtl/mult_sched_pkg.sv
// Shared defaults and FSM encoding for the time-shared multiplier scheduler.
// Purely declarative; no logic, no latency, no flow control.
package mult_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BIT_WIDTH = 7;

  function automatic int out_width(input int bw);
    return 2 * bw;
  endfunction

  localparam int DEF_OUT_WIDTH = out_width(DEF_BIT_WIDTH);

  // A single requester still needs a 1-bit ID port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mult_share_sched_rr_select.sv
// Round-robin pick: first valid requester at or above ptr, wrapping at NUM_REQ-1.
// Combinational, zero latency; no flow control of its own.
module rr_select
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  // Scan from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % NUM_REQ]) begin
        idx = IDW'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end

  assign grant = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one external combinational multiplier among NUM_REQ requesters.
// Grant to rsp_valid is 2 cycles; result held until rsp_ready, no grants while busy.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int OUT_WIDTH = out_width(BIT_WIDTH),
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_inp,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BIT_WIDTH-1:0]          mul_inp,
  input  logic [OUT_WIDTH-1:0]          mul_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [OUT_WIDTH-1:0]          rsp_data
);

  sched_state_t          state;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        owner;
  logic [BIT_WIDTH-1:0]  opnd;
  logic [NUM_REQ-1:0]    sel_grant;
  logic [IDW-1:0]        sel_idx;
  logic                  sel_any;
  logic [IDW-1:0]        ptr_nxt;
  logic [BIT_WIDTH-1:0]  opnd_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign opnd_arr[i] = req_inp[i*BIT_WIDTH +: BIT_WIDTH];
  end

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign ptr_nxt = (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + IDW'(1);

  // Grant is a same-cycle strobe; rst_n gating keeps it quiet while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? sel_grant : '0;
  assign mul_inp   = opnd;
  assign rsp_id    = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      opnd      <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            opnd  <= opnd_arr[sel_idx];
            owner <= sel_idx;
            ptr   <= ptr_nxt;
            state <= EVAL;
          end
        end
        // The multiplier has had a full cycle on the stable operand register.
        EVAL: begin
          rsp_data  <= mul_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
